// File: rtl/updi_cmd_sequencer.sv
// Command sequencer: turns one host-level UPDI access (LDCS/STCS/LDS/STS) into a
// TX (and optional RX) transaction on updi_interface and reports the result.
package updi_pkg;
    typedef enum logic [2:0] {
        UPDI_LDS    = 3'd0,
        UPDI_LD     = 3'd1,
        UPDI_STS    = 3'd2,
        UPDI_ST     = 3'd3,
        UPDI_LDCS   = 3'd4,
        UPDI_REPEAT = 3'd5,
        UPDI_STCS   = 3'd6,
        UPDI_KEY    = 3'd7
    } updi_instruction;
endpackage

module updi_cmd_sequencer
    import updi_pkg::*;
#(
    parameter int MAX_DATA_SIZE  = 64,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_op,
    input  logic [3:0]                     req_cs_addr,
    input  logic [15:0]                    req_addr,
    input  logic [7:0]                     req_wdata,
    output logic                           rsp_valid,
    output logic [7:0]                     rsp_rdata,
    output logic                           rsp_error,
    output updi_instruction                instruction,
    output logic [1:0]                     size_a,
    output logic [1:0]                     size_b,
    output logic [1:0]                     ptr,
    output logic [1:0]                     size_c,
    output logic [3:0]                     cs_addr,
    output logic                           sib,
    output logic [MAX_DATA_SIZE-1:0][7:0]  data,
    output logic [DATA_ADDR_BITS-1:0]      data_len,
    output logic [MAX_DATA_SIZE-1:0]       wait_ack_after,
    output logic                           tx_start,
    input  logic                           tx_ready,
    output logic [DATA_ADDR_BITS-1:0]      rx_n_bytes,
    output logic                           rx_start,
    input  logic                           rx_ready,
    input  logic                           ack_error,
    input  logic [7:0]                     rx_fifo_data,
    input  logic                           rx_fifo_empty,
    output logic                           rx_fifo_rd_en
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TX_START, S_TX_BUSY, S_TX_WAIT, S_RX_START, S_RX_WAIT, S_POP, S_DONE
    } state_t;

    state_t           state_r;
    logic [TMR_W-1:0] timer_r;
    logic             timeout_s;

    assign timeout_s = (timer_r == TMR_LAST);
    assign sib       = 1'b0;

    // Sequencer FSM with registered interface fields, strobes and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            timer_r        <= '0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 8'h00;
            rsp_error      <= 1'b0;
            instruction    <= UPDI_LDS;
            size_a         <= 2'd0;
            size_b         <= 2'd0;
            ptr            <= 2'd0;
            size_c         <= 2'd0;
            cs_addr        <= 4'h0;
            data           <= '0;
            data_len       <= '0;
            wait_ack_after <= '0;
            rx_n_bytes     <= '0;
            tx_start       <= 1'b0;
            rx_start       <= 1'b0;
            rx_fifo_rd_en  <= 1'b0;
        end else begin
            // Strobes are single-cycle; the timer runs only while waiting on the datapath.
            tx_start      <= 1'b0;
            rx_start      <= 1'b0;
            rx_fifo_rd_en <= 1'b0;
            rsp_valid     <= 1'b0;
            timer_r       <= (state_r == S_IDLE || state_r == S_DONE) ? '0 : timer_r + TMR_W'(1);
            case (state_r)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready      <= 1'b0;
                        rsp_rdata      <= 8'h00;
                        rsp_error      <= 1'b0;
                        size_a         <= 2'd1;
                        size_b         <= 2'd0;
                        ptr            <= 2'd0;
                        size_c         <= 2'd0;
                        cs_addr        <= 4'h0;
                        data           <= '0;
                        data_len       <= '0;
                        wait_ack_after <= '0;
                        rx_n_bytes     <= '0;
                        case (req_op)
                            2'd0: begin
                                instruction <= UPDI_LDCS;
                                cs_addr     <= req_cs_addr;
                                rx_n_bytes  <= DATA_ADDR_BITS'(1);
                            end
                            2'd1: begin
                                instruction <= UPDI_STCS;
                                cs_addr     <= req_cs_addr;
                                data[0]     <= req_wdata;
                                data_len    <= DATA_ADDR_BITS'(1);
                            end
                            2'd2: begin
                                instruction <= UPDI_LDS;
                                data[0]     <= req_addr[7:0];
                                data[1]     <= req_addr[15:8];
                                data_len    <= DATA_ADDR_BITS'(2);
                                rx_n_bytes  <= DATA_ADDR_BITS'(1);
                            end
                            2'd3: begin
                                instruction       <= UPDI_STS;
                                data[0]           <= req_addr[7:0];
                                data[1]           <= req_addr[15:8];
                                data[2]           <= req_wdata;
                                data_len          <= DATA_ADDR_BITS'(3);
                                wait_ack_after[1] <= 1'b1;
                                wait_ack_after[2] <= 1'b1;
                            end
                            default: instruction <= UPDI_LDCS;
                        endcase
                        timer_r <= '0;
                        state_r <= S_TX_START;
                    end
                end
                S_TX_START: begin
                    if (tx_ready) begin
                        tx_start <= 1'b1;
                        timer_r  <= '0;
                        state_r  <= S_TX_BUSY;
                    end else if (timeout_s) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 8'h00;
                        timer_r   <= '0;
                        state_r   <= S_DONE;
                    end
                end
                S_TX_BUSY: begin
                    // A second cycle of tx_ready high means the transfer already finished.
                    if (!tx_ready || timer_r != '0) begin
                        timer_r <= '0;
                        state_r <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    if (tx_ready) begin
                        timer_r <= '0;
                        if (ack_error) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            state_r   <= S_DONE;
                        end else if (rx_n_bytes == '0) begin
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            state_r   <= S_DONE;
                        end else begin
                            state_r <= S_RX_START;
                        end
                    end else if (timeout_s) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 8'h00;
                        timer_r   <= '0;
                        state_r   <= S_DONE;
                    end
                end
                S_RX_START: begin
                    if (rx_ready) begin
                        rx_start <= 1'b1;
                        timer_r  <= '0;
                        state_r  <= S_RX_WAIT;
                    end else if (timeout_s) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 8'h00;
                        timer_r   <= '0;
                        state_r   <= S_DONE;
                    end
                end
                S_RX_WAIT: begin
                    if (rx_ready && !rx_fifo_empty) begin
                        rx_fifo_rd_en <= 1'b1;
                        timer_r       <= '0;
                        state_r       <= S_POP;
                    end else if (timeout_s) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 8'h00;
                        timer_r   <= '0;
                        state_r   <= S_DONE;
                    end
                end
                S_POP: begin
                    // FWFT FIFO: the head word is valid while rd_en is high.
                    rsp_rdata <= rx_fifo_data;
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b0;
                    timer_r   <= '0;
                    state_r   <= S_DONE;
                end
                S_DONE: begin
                    rsp_error <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
